// File: rtl/io_bus_if.sv
// CPU-side memory-mapped I/O bus of the io_hub: byte address, read/write strobes,
// store data and combinational load data.
interface io_bus_if;
  logic [31:0] addr;
  logic        io_read;
  logic        io_write;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output addr, output io_read, output io_write, output wdata, input rdata);
  modport slave  (input addr, input io_read, input io_write, input wdata, output rdata);
endinterface

// File: rtl/io_hub.sv
// Memory-mapped I/O hub: half-word LED registers, synchronised and debounced
// switches, and a sticky clear-on-read "switch changed" flag in the 0xFFFFFC00 window.
module io_hub #(
  parameter int SW_WIDTH        = 16,
  parameter int LED_WIDTH       = 24,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic                 clock,
  input  logic                 reset,
  io_bus_if.slave              bus,
  input  logic [SW_WIDTH-1:0]  switches,
  output logic [LED_WIDTH-1:0] leds,
  output logic                 sw_irq
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [7:0] OFF_LED_LO = 8'h60;
  localparam logic [7:0] OFF_LED_HI = 8'h62;
  localparam logic [7:0] OFF_SW_LO  = 8'h70;
  localparam logic [7:0] OFF_SW_HI  = 8'h72;
  localparam logic [7:0] OFF_STATUS = 8'h74;

  logic [LED_WIDTH-1:0] leds_r;
  logic [SW_WIDTH-1:0]  sync1_r;
  logic [SW_WIDTH-1:0]  sync2_r;
  logic [SW_WIDTH-1:0]  cand_r;
  logic [SW_WIDTH-1:0]  stable_r;
  logic [CNT_W-1:0]     cnt_r;
  logic                 changed_r;

  logic        sel_s;
  logic [7:0]  offset_s;
  logic        wr_lo_s;
  logic        wr_hi_s;
  logic        status_rd_s;
  logic        commit_s;
  logic [31:0] led_full_s;
  logic [31:0] led_next_s;
  logic [31:0] sw_full_s;
  logic [31:0] rdata_s;
  logic        unused_s;

  // Address bits 9:8 are don't-care inside the window; only wdata[15:0] is ever stored.
  assign unused_s = &{1'b0, bus.addr[9:8], bus.wdata[31:16], led_next_s};

  assign sel_s       = (bus.addr[31:10] == 22'h3F_FFFF);
  assign offset_s    = bus.addr[7:0];
  assign wr_lo_s     = bus.io_write && sel_s && (offset_s == OFF_LED_LO);
  assign wr_hi_s     = bus.io_write && sel_s && (offset_s == OFF_LED_HI);
  assign status_rd_s = bus.io_read && sel_s && (offset_s == OFF_STATUS);
  assign commit_s    = (sync2_r == cand_r) && (cnt_r == CNT_MAX) && (cand_r != stable_r);

  // Zero-extend the narrow LED and switch state to the 32-bit register view.
  always_comb begin
    led_full_s = 32'h0;
    sw_full_s  = 32'h0;
    led_full_s[LED_WIDTH-1:0] = leds_r;
    sw_full_s[SW_WIDTH-1:0]   = stable_r;
  end

  // Merge a half-word store into the LED image; bits above LED_WIDTH drop on truncation.
  always_comb begin
    led_next_s = led_full_s;
    if (wr_lo_s) begin
      led_next_s[15:0] = bus.wdata[15:0];
    end else if (wr_hi_s) begin
      led_next_s[31:16] = bus.wdata[15:0];
    end else begin
      led_next_s = led_full_s;
    end
  end

  // LED register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      leds_r <= {LED_WIDTH{1'b0}};
    end else begin
      leds_r <= led_next_s[LED_WIDTH-1:0];
    end
  end

  // Two-flop synchroniser followed by a saturating-count debouncer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_r  <= {SW_WIDTH{1'b0}};
      sync2_r  <= {SW_WIDTH{1'b0}};
      cand_r   <= {SW_WIDTH{1'b0}};
      stable_r <= {SW_WIDTH{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      sync1_r <= switches;
      sync2_r <= sync1_r;
      if (sync2_r != cand_r) begin
        cand_r <= sync2_r;
        cnt_r  <= {CNT_W{1'b0}};
      end else if (cnt_r < CNT_MAX) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else if (commit_s) begin
        stable_r <= cand_r;
      end else begin
        stable_r <= stable_r;
      end
    end
  end

  // Sticky changed flag; a commit on the same edge as a STATUS read keeps it set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      changed_r <= 1'b0;
    end else if (commit_s) begin
      changed_r <= 1'b1;
    end else if (status_rd_s) begin
      changed_r <= 1'b0;
    end else begin
      changed_r <= changed_r;
    end
  end

  // Load data is combinational so the single-cycle datapath sees it in the same cycle.
  always_comb begin
    rdata_s = 32'h0;
    if (bus.io_read && sel_s) begin
      case (offset_s)
        OFF_LED_LO: rdata_s = {16'h0, led_full_s[15:0]};
        OFF_LED_HI: rdata_s = {16'h0, led_full_s[31:16]};
        OFF_SW_LO:  rdata_s = {16'h0, sw_full_s[15:0]};
        OFF_SW_HI:  rdata_s = {16'h0, sw_full_s[31:16]};
        OFF_STATUS: rdata_s = {31'h0, changed_r};
        default:    rdata_s = 32'h0;
      endcase
    end else begin
      rdata_s = 32'h0;
    end
  end

  assign bus.rdata = rdata_s;
  assign leds      = leds_r;
  assign sw_irq    = changed_r;

endmodule

// File: tb/tb_io_hub.sv
// Scoreboard bench for io_hub: stimulus queues expected values, a negedge
// monitor pops and compares them against rdata, leds and sw_irq.
module tb_io_hub;
  localparam int SW_W  = 16;
  localparam int LED_W = 24;
  localparam int DB    = 8;

  localparam int K_RD  = 0;
  localparam int K_LED = 1;
  localparam int K_IRQ = 2;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } chk_t;

  logic             clock = 1'b0;
  logic             reset;
  logic [SW_W-1:0]  switches;
  logic [LED_W-1:0] leds;
  logic             sw_irq;

  chk_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  io_bus_if bus ();

  io_hub #(.SW_WIDTH(SW_W), .LED_WIDTH(LED_W), .DEBOUNCE_CYCLES(DB)) dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus),
    .switches(switches),
    .leds    (leds),
    .sw_irq  (sw_irq)
  );

  always #5 clock = ~clock;

  // Monitor: compare every queued expectation against the DUT outputs at the falling edge.
  always @(negedge clock) begin
    chk_t        c;
    logic [31:0] got;
    while (q.size() > 0) begin
      c = q.pop_front();
      case (c.kind)
        K_RD:    got = bus.rdata;
        K_LED:   got = {8'h0, leds};
        default: got = {31'h0, sw_irq};
      endcase
      n_tests++;
      if (got !== c.exp) begin
        n_fail++;
        $display("FAIL %s: got %h, expected %h", c.name, got, c.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_val(input int kind, input logic [31:0] v, input string name);
    chk_t c;
    c.kind = kind;
    c.exp  = v;
    c.name = name;
    q.push_back(c);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.addr     = a;
    bus.wdata    = d;
    bus.io_write = 1'b1;
    tick();
    bus.io_write = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string name);
    bus.addr    = a;
    bus.io_read = 1'b1;
    expect_val(K_RD, exp, name);
    tick();
    bus.io_read = 1'b0;
  endtask

  // Switches changed just after an edge: sw_irq must be low after edge DB+2 and high after DB+3.
  task automatic wait_commit(input string name);
    for (int i = 1; i <= DB + 3; i++) begin
      tick();
      expect_val(K_IRQ, (i == DB + 3) ? 32'd1 : 32'd0, $sformatf("%s_irq_edge%0d", name, i));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    switches     = 16'hFFFF;
    bus.addr     = 32'h0;
    bus.wdata    = 32'h0;
    bus.io_read  = 1'b0;
    bus.io_write = 1'b0;
    tick();
    tick();
    expect_val(K_LED, 32'h0, "rst_leds");
    expect_val(K_IRQ, 32'h0, "rst_irq");
    bus_read(32'hFFFF_FC70, 32'h0, "rst_sw_lo");
    reset    = 1'b0;
    switches = 16'h0000;
    tick();

    // LED half-word writes, upper byte of LED_HI beyond LED_WIDTH discarded
    bus_write(32'hFFFF_FC60, 32'h1234_ABCD);
    expect_val(K_LED, 32'h0000_ABCD, "led_lo_write");
    bus_write(32'hFFFF_FC62, 32'h0000_00FF);
    expect_val(K_LED, 32'h00FF_ABCD, "led_hi_write");
    bus_read(32'hFFFF_FC62, 32'h0000_00FF, "led_hi_read");
    bus_read(32'hFFFF_FC60, 32'h0000_ABCD, "led_lo_read");
    bus_write(32'hFFFF_FC62, 32'h0000_A55A);
    expect_val(K_LED, 32'h005A_ABCD, "led_hi_trunc");
    bus_read(32'hFFFF_FC62, 32'h0000_005A, "led_hi_trunc_read");
    bus_write(32'hFFFF_FC62, 32'h0000_00FF);

    // Decode misses
    bus_write(32'hFFFF_F860, 32'h0000_FFFF);
    expect_val(K_LED, 32'h00FF_ABCD, "dec_outside_window");
    bus_write(32'hFFFF_FC64, 32'h0000_FFFF);
    expect_val(K_LED, 32'h00FF_ABCD, "dec_unmapped_write");
    bus_read(32'hFFFF_FC78, 32'h0, "dec_unmapped_read");
    bus.addr = 32'hFFFF_FC60;
    expect_val(K_RD, 32'h0, "rd_idle_zero");
    tick();

    // Debounce accept and clear-on-read
    switches = 16'h00A5;
    wait_commit("accept");
    bus_read(32'hFFFF_FC70, 32'h0000_00A5, "accept_sw_lo");
    bus_read(32'hFFFF_FC72, 32'h0, "accept_sw_hi");
    bus_read(32'hFFFF_FC74, 32'h1, "status_set");
    expect_val(K_IRQ, 32'h0, "status_cleared_irq");
    bus_read(32'hFFFF_FC74, 32'h0, "status_after_clear");

    // Return to zero, then a 5-clock glitch that must be rejected
    switches = 16'h0000;
    repeat (DB + 3) tick();
    bus_read(32'hFFFF_FC74, 32'h1, "zero_status");
    switches = 16'h0001;
    repeat (5) tick();
    switches = 16'h0000;
    repeat (DB + 6) tick();
    expect_val(K_IRQ, 32'h0, "glitch_irq");
    bus_read(32'hFFFF_FC70, 32'h0, "glitch_sw_lo");

    // Commit on the same edge as a STATUS read: set wins
    switches = 16'h0003;
    repeat (DB + 3) tick();
    expect_val(K_IRQ, 32'h1, "race_pre_irq");
    switches = 16'h0000;
    repeat (DB + 2) tick();
    bus_read(32'hFFFF_FC74, 32'h1, "race_status_read");
    expect_val(K_IRQ, 32'h1, "race_irq_kept");
    bus_read(32'hFFFF_FC70, 32'h0, "race_sw_lo");
    bus_read(32'hFFFF_FC74, 32'h1, "race_status_again");
    expect_val(K_IRQ, 32'h0, "race_irq_cleared");

    // Reset mid-count and mid-write
    switches = 16'h00F0;
    repeat (4) tick();
    bus.addr     = 32'hFFFF_FC60;
    bus.wdata    = 32'h0000_5555;
    bus.io_write = 1'b1;
    reset        = 1'b1;
    expect_val(K_LED, 32'h0, "rst_async_leds");
    tick();
    reset        = 1'b0;
    bus.io_write = 1'b0;
    expect_val(K_LED, 32'h0, "rst_write_lost");
    wait_commit("rst_restart");
    bus_read(32'hFFFF_FC70, 32'h0000_00F0, "rst_restart_sw_lo");

    repeat (2) tick();
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
